// File: rtl/mem_stage.sv
// mem_stage: dual-issue memory stage. It holds one EX/MEM pipeline register,
// extracts load data for the single loading slot, and keeps a hold buffer so
// load data survives a downstream stall.
module mem_stage #(
  parameter int unsigned SLOT_IN_WD  = 75,
  parameter int unsigned SLOT_OUT_WD = 71
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [5:0]                  stall,
  input  logic [2*SLOT_IN_WD-1:0]     ex_to_mem_bus,
  input  logic [31:0]                 data_sram_rdata,
  output logic [2*SLOT_OUT_WD-1:0]    mem_to_wb_bus,
  output logic [75:0]                 mem_to_rf_bus
);

  // Field positions inside one EX-to-MEM slot (LSB first)
  localparam int unsigned LD_TYPE_LSB = 0;
  localparam int unsigned LD_EN_BIT   = 3;
  localparam int unsigned RES_LSB     = 4;
  localparam int unsigned WADDR_LSB   = 36;
  localparam int unsigned WE_BIT      = 41;
  localparam int unsigned PC_LSB      = 42;
  localparam int unsigned VALID_BIT   = SLOT_IN_WD - 1;
  localparam int unsigned RF_SLOT_WD  = 38;

  logic [2*SLOT_IN_WD-1:0] stage_q;
  logic [31:0]             hold_data;
  logic                    hold_valid;

  logic [SLOT_IN_WD-1:0]   s1;
  logic [SLOT_IN_WD-1:0]   s2;
  logic                    ld_s1;
  logic                    ld_s2;
  logic                    ld_pending;
  logic [1:0]              ld_off;
  logic [2:0]              ld_type;
  logic [31:0]             rdata_src;
  logic [31:0]             ld_data;

  // Stall bits owned by other stages are not used here
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // Byte/halfword/word extraction with sign or zero extension
  function automatic logic [31:0] extract(input logic [2:0]  t,
                                          input logic [1:0]  off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {24'd0, b};
      3'b010:  r = {{16{h[15]}}, h};
      3'b011:  r = {16'd0, h};
      3'b100:  r = w;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Stage register: flush > capture > bubble > hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (!stall[3]) begin
      stage_q <= ex_to_mem_bus;
    end else if (!stall[4]) begin
      stage_q <= '0;
    end
  end

  // Hold buffer: latch the SRAM word once while a load is stuck in this stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
    end else if (flush) begin
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
    end else if (!stall[4]) begin
      hold_valid <= 1'b0;
    end else if (ld_pending && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_data  <= data_sram_rdata;
    end
  end

  // Select the loading slot (slot1 wins) and extract its data
  always_comb begin
    s1         = stage_q[SLOT_IN_WD-1:0];
    s2         = stage_q[2*SLOT_IN_WD-1:SLOT_IN_WD];
    ld_s1      = s1[VALID_BIT] & s1[LD_EN_BIT];
    ld_s2      = s2[VALID_BIT] & s2[LD_EN_BIT] & ~ld_s1;
    ld_pending = ld_s1 | ld_s2;
    ld_off     = ld_s1 ? s1[RES_LSB +: 2] : s2[RES_LSB +: 2];
    ld_type    = ld_s1 ? s1[LD_TYPE_LSB +: 3] : s2[LD_TYPE_LSB +: 3];
    rdata_src  = hold_valid ? hold_data : data_sram_rdata;
    ld_data    = extract(ld_type, ld_off, rdata_src);
  end

  // Assemble WB and forwarding buses; invalid slots read as zero
  always_comb begin
    logic [SLOT_IN_WD-1:0] slot;
    logic                  win;
    logic [31:0]           wdata;
    mem_to_wb_bus = '0;
    mem_to_rf_bus = '0;
    slot          = '0;
    win           = 1'b0;
    wdata         = 32'd0;
    for (int i = 0; i < 2; i++) begin
      slot  = stage_q[i*SLOT_IN_WD +: SLOT_IN_WD];
      win   = (i == 0) ? ld_s1 : ld_s2;
      wdata = win ? ld_data : slot[RES_LSB +: 32];
      if (slot[VALID_BIT]) begin
        mem_to_wb_bus[i*SLOT_OUT_WD +: SLOT_OUT_WD] =
          {1'b1, slot[PC_LSB +: 32], slot[WE_BIT], slot[WADDR_LSB +: 5], wdata};
        mem_to_rf_bus[i*RF_SLOT_WD +: RF_SLOT_WD] =
          {slot[WE_BIT], slot[WADDR_LSB +: 5], wdata};
      end
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter SLOT_IN_WD, default 75, SHALL be the width of one slot of the EX-to-MEM bus.
REQ-002 Parameter SLOT_OUT_WD, default 71, SHALL be the width of one slot of the MEM-to-WB bus.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush  input  1  SHALL be the pipeline flush request, active high.
REQ-006 stall  input  6  SHALL be the pipeline stall bus; bit=1 means Stop.
REQ-007 ex_to_mem_bus  input  150  SHALL be {slot2, slot1}; each slot is {valid, pc[31:0], rf_we, rf_waddr[4:0], ex_result[31:0], ld_en, ld_type[2:0]}, MSB first.
REQ-008 data_sram_rdata  input  32  SHALL be the data SRAM read word, valid in the cycle after the EX-stage request.
REQ-009 mem_to_wb_bus  output  142  SHALL be {slot2, slot1}; each slot is {valid, pc, rf_we, rf_waddr, wdata}.
REQ-010 mem_to_rf_bus  output  76  SHALL be {slot2, slot1} forwarding; each slot is {rf_we, rf_waddr, wdata}.

Function
REQ-011 The stage register SHALL capture ex_to_mem_bus when stall[3]=0.
REQ-012 The stage register SHALL load all-zero (bubble) when stall[3]=1 and stall[4]=0.
REQ-013 The stage register SHALL hold its value when stall[3]=1 and stall[4]=1.
REQ-014 flush=1 SHALL zero the stage register and clear the hold buffer, with priority over every stall case.
REQ-015 Upstream guarantees at most one slot with ld_en=1 per pair; the slot with ld_en=1 SHALL receive the load data, and if both slots are set, slot1 SHALL win.
REQ-016 The load address SHALL be ex_result of the loading slot; byte offset is ex_result[1:0].
REQ-017 ld_type 000 SHALL produce lb: the byte at the offset, sign-extended.
REQ-018 ld_type 001 SHALL produce lbu: the byte at the offset, zero-extended.
REQ-019 ld_type 010 SHALL produce lh: the halfword at offset[1], sign-extended.
REQ-020 ld_type 011 SHALL produce lhu: the halfword at offset[1], zero-extended.
REQ-021 ld_type 100 SHALL produce lw: the whole word.
REQ-022 ld_type 101-111 SHALL produce wdata=0.
REQ-023 Misaligned offsets SHALL be ignored (offset[0] for halfword, the whole offset for word); no exception is raised here.
REQ-024 A slot with ld_en=0 SHALL output wdata=ex_result.
REQ-025 A hold buffer (hold_data[31:0], hold_valid) SHALL capture data_sram_rdata on the first cycle the register holds a valid load and stall[4]=1.
REQ-026 While hold_valid=1, extraction SHALL use hold_data instead of data_sram_rdata.
REQ-027 hold_valid SHALL clear on the first cycle with stall[4]=0, i.e. when the instruction advances; new loads then use live rdata.
REQ-028 If a new load enters the register in the same cycle hold_valid clears, the new load SHALL use live rdata.
REQ-029 mem_to_rf_bus slot SHALL carry rf_we AND valid, rf_waddr, wdata, combinationally, for same-cycle forwarding.
REQ-030 mem_to_wb_bus SHALL be combinational from the register plus extracted data; latency from EX capture to WB bus is one cycle.
REQ-031 Invalid slots SHALL drive the whole output slot to zero.

Reset
REQ-032 rst=0 SHALL asynchronously zero the stage register, hold_data and hold_valid; all outputs read 0 while rst=0.
REQ-033 Release of rst SHALL be synchronised upstream; the first capture occurs on the first rising clk with rst=1.
REQ-034 Reset asserted mid-stall SHALL discard held data; there is no recovery of in-flight loads.

Verification
REQ-035 Test lb: slot1 valid load, ld_type=000, ex_result=0x1003, rdata=0x80FF_1234 -> next cycle slot1 wdata=0xFFFF_FF80, slot2 wdata=slot2 ex_result.
REQ-036 Test lhu: ld_type=011, ex_result=0x2002, rdata=0xABCD_0000 -> wdata=0x0000_ABCD.
REQ-037 Test the hold buffer: lw in the register, stall[4:3]=11 for 3 cycles, rdata 0x1111_1111 on the first cycle then 0xDEAD_BEEF -> wdata stays 0x1111_1111 throughout and after release.
REQ-038 Test the bubble: stall[3]=1, stall[4]=0 -> next cycle both valid=0, mem_to_rf_bus rf_we=0.
REQ-039 Test flush with stall: flush=1 with stall[4:3]=11 -> register zero and hold_valid=0 next cycle.
REQ-040 Test async reset: rst driven low between clock edges while a valid pair is held -> outputs zero immediately, before the next edge.
